// File: rtl/psram_line_fetcher.sv
// rtl/psram_line_fetcher.sv - PSRAM video line fetcher with FWFT line buffer

// Line buffer: FWFT queue, head word read combinationally from storage.
module psram_line_buffer #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic        empty,
  output logic        full
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  // count only ever reaches DEPTH, so its top bit alone marks full
  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; a flush in the same cycle drops the word
  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keep count steady
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module psram_line_fetcher #(
  parameter int          WORDS_PER_LINE = 40,
  parameter logic [20:0] BASE_ADDR      = 21'h0,
  parameter int          DEPTH          = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_index,
  output logic        psram_rd,
  output logic [20:0] psram_addr,
  input  logic        psram_busy,
  input  logic [15:0] psram_q,
  input  logic        pix_rd,
  output logic [15:0] pix_q,
  output logic        pix_valid,
  output logic        fetch_active,
  output logic        underrun
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  localparam logic [20:0] LINE_STRIDE = 21'(WORDS_PER_LINE);
  localparam logic [6:0]  LAST_WORD   = 7'(WORDS_PER_LINE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  line_reg;
  logic [6:0]  word_cnt;
  logic        discard;
  logic        buf_wr;
  logic        buf_empty;
  logic        buf_full;
  logic [20:0] fetch_addr;

  // Address arithmetic wraps naturally at 21 bits
  assign fetch_addr   = BASE_ADDR + 21'(line_reg) * LINE_STRIDE + 21'(word_cnt);
  assign psram_addr   = psram_rd ? fetch_addr : '0;
  assign pix_valid    = !buf_empty;
  assign fetch_active = (state != IDLE);

  psram_line_buffer #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .flush  (line_start),
    .wr_en  (buf_wr),
    .wr_data(psram_q),
    .rd_en  (pix_rd),
    .rd_data(pix_q),
    .empty  (buf_empty),
    .full   (buf_full)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read strobe and capture strobe; a new line request
  // restarts issue but never cuts short a read already handed to the controller
  always_comb begin
    state_nxt = state;
    psram_rd  = 1'b0;
    buf_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!line_start && !psram_busy && !buf_full) begin
          psram_rd  = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (psram_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!psram_busy) begin
          if (discard || line_start) begin
            state_nxt = ISSUE;
          end else begin
            buf_wr    = 1'b1;
            state_nxt = (word_cnt == LAST_WORD) ? IDLE : ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line latch, word counter and the drop-next-completion flag after an abort
  always_ff @(posedge clk) begin
    if (reset) begin
      line_reg <= '0;
      word_cnt <= '0;
      discard  <= 1'b0;
    end else begin
      if (line_start) begin
        line_reg <= line_index;
        word_cnt <= '0;
      end else if (buf_wr) begin
        word_cnt <= word_cnt + 7'd1;
      end
      if (line_start && (state == WAIT_HI || (state == WAIT_LO && psram_busy))) begin
        discard <= 1'b1;
      end else if (state == WAIT_LO && !psram_busy) begin
        discard <= 1'b0;
      end
    end
  end

  // Sticky underrun: pop on empty sets it, a new line request clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (pix_rd && buf_empty) begin
      underrun <= 1'b1;
    end else if (line_start) begin
      underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_psram_line_fetcher.sv
// tb/tb_psram_line_fetcher.sv - self-checking bench for psram_line_fetcher
module tb_psram_line_fetcher;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  line_start;
  logic [7:0]  line_index [2];
  logic [1:0]  psram_rd;
  logic [20:0] psram_addr [2];
  logic [1:0]  psram_busy;
  logic [15:0] psram_q [2];
  logic [1:0]  pix_rd;
  logic [15:0] pix_q [2];
  logic [1:0]  pix_valid;
  logic [1:0]  fetch_active;
  logic [1:0]  underrun;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // instance 0: 40 words/line from address 0; instance 1: 64 words/line near top of memory
  psram_line_fetcher #(.WORDS_PER_LINE(40), .BASE_ADDR(21'h0), .DEPTH(64)) dut_a (
    .clk(clk), .reset(reset), .line_start(line_start[0]), .line_index(line_index[0]),
    .psram_rd(psram_rd[0]), .psram_addr(psram_addr[0]), .psram_busy(psram_busy[0]),
    .psram_q(psram_q[0]), .pix_rd(pix_rd[0]), .pix_q(pix_q[0]), .pix_valid(pix_valid[0]),
    .fetch_active(fetch_active[0]), .underrun(underrun[0]));

  psram_line_fetcher #(.WORDS_PER_LINE(64), .BASE_ADDR(21'h1FFFF0), .DEPTH(64)) dut_b (
    .clk(clk), .reset(reset), .line_start(line_start[1]), .line_index(line_index[1]),
    .psram_rd(psram_rd[1]), .psram_addr(psram_addr[1]), .psram_busy(psram_busy[1]),
    .psram_q(psram_q[1]), .pix_rd(pix_rd[1]), .pix_q(pix_q[1]), .pix_valid(pix_valid[1]),
    .fetch_active(fetch_active[1]), .underrun(underrun[1]));

  function automatic int wpl(input int i);
    return (i == 0) ? 40 : 64;
  endfunction

  function automatic logic [20:0] base(input int i);
    return (i == 0) ? 21'h0 : 21'h1FFFF0;
  endfunction

  function automatic logic [15:0] pat(input logic [20:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // PSRAM controller: busy for 4 cycles after each read, data on the falling cycle
  int          rem [2];
  logic [20:0] pend [2];
  logic [20:0] a_s [2];
  logic [1:0]  rd_s;
  initial begin
    for (int i = 0; i < 2; i++) begin
      psram_busy[i] = 1'b0;
      psram_q[i]    = 16'h0;
      rem[i]        = 0;
      pend[i]       = 21'h0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rd_s[i] = psram_rd[i];
        a_s[i]  = psram_addr[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            psram_busy[i] = 1'b0;
            psram_q[i]    = pat(pend[i]);
          end
        end else if (rd_s[i]) begin
          psram_busy[i] = 1'b1;
          rem[i]        = 4;
          pend[i]       = a_s[i];
        end
      end
    end
  end

  // Reference model: expected buffer contents as a queue, line generations tag reads
  logic [15:0] mq [2][$];
  logic [20:0] rd_log [2][$];
  bit          m_active [2];
  bit          m_under [2];
  int          m_line [2];
  int          m_k [2];
  int          m_gen [2];
  int          out_st [2];
  int          out_gen [2];
  logic [20:0] out_addr [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int          sz;
      bit          comp;
      logic [20:0] ea;
      sz = mq[i].size();
      if (!reset) begin
        chk("pix_valid", 32'(pix_valid[i]), 32'(sz != 0));
        if (sz != 0) chk("pix_q", 32'(pix_q[i]), 32'(mq[i][0]));
        chk("fetch_active", 32'(fetch_active[i]), 32'(m_active[i]));
        chk("underrun", 32'(underrun[i]), 32'(m_under[i]));
        if (psram_rd[i]) begin
          ea = base(i) + 21'(m_line[i] * wpl(i) + m_k[i]);
          chk("rd_addr", 32'(psram_addr[i]), 32'(ea));
          chk("rd_while_busy", 32'(psram_busy[i]), 32'd0);
          chk("rd_while_full", 32'(sz < 64), 32'd1);
          chk("rd_while_idle", 32'(m_active[i]), 32'd1);
          rd_log[i].push_back(psram_addr[i]);
        end
      end
      comp = (out_st[i] == 2) && !psram_busy[i];
      if (comp) out_st[i] = 0;
      else if (out_st[i] == 1 && psram_busy[i]) out_st[i] = 2;
      if (reset) begin
        mq[i].delete();
        m_active[i] = 1'b0;
        m_under[i]  = 1'b0;
        m_line[i]   = 0;
        m_k[i]      = 0;
        m_gen[i]++;
      end else begin
        if (pix_rd[i] && sz == 0) m_under[i] = 1'b1;
        else if (line_start[i]) m_under[i] = 1'b0;
        if (psram_rd[i]) begin
          out_st[i]   = 1;
          out_addr[i] = psram_addr[i];
          out_gen[i]  = m_gen[i];
        end
        if (line_start[i]) begin
          m_gen[i]++;
          mq[i].delete();
          m_line[i]   = int'(line_index[i]);
          m_k[i]      = 0;
          m_active[i] = 1'b1;
        end else begin
          if (pix_rd[i] && sz != 0) void'(mq[i].pop_front());
          if (comp && out_gen[i] == m_gen[i]) begin
            mq[i].push_back(pat(out_addr[i]));
            m_k[i]++;
            if (m_k[i] == wpl(i)) m_active[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_line(input int i, input logic [7:0] idx);
    line_index[i] = idx;
    line_start[i] = 1'b1;
    tick();
    line_start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while (fetch_active[i] && n < budget) begin
      tick();
      n++;
    end
    chk("fetch_timeout", 32'(fetch_active[i]), 32'd0);
  endtask

  task automatic wait_busy(input int i);
    int n = 0;
    while (!psram_busy[i] && n < 50) begin
      tick();
      n++;
    end
    chk("busy_timeout", 32'(psram_busy[i]), 32'd1);
  endtask

  task automatic drain(input int i);
    int n = 0;
    while (pix_valid[i] && n < 100) begin
      pix_rd[i] = 1'b1;
      tick();
      n++;
    end
    pix_rd[i] = 1'b0;
    chk("drain", 32'(pix_valid[i]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset         = 1'b1;
    line_start    = 2'b00;
    pix_rd        = 2'b00;
    line_index[0] = 8'd0;
    line_index[1] = 8'd0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rd", 32'(psram_rd[i]), 32'd0);
      chk("rst_addr", 32'(psram_addr[i]), 32'd0);
      chk("rst_valid", 32'(pix_valid[i]), 32'd0);
      chk("rst_active", 32'(fetch_active[i]), 32'd0);
      chk("rst_underrun", 32'(underrun[i]), 32'd0);
    end

    // underrun is sticky
    tick();
    pix_rd[0] = 1'b1;
    tick();
    pix_rd[0] = 1'b0;
    @(negedge clk);
    chk("underrun_set", 32'(underrun[0]), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("underrun_hold", 32'(underrun[0]), 32'd1);

    // line 3: one-cycle latency, addresses 120..159, underrun cleared
    tick();
    rd_log[0].delete();
    start_line(0, 8'd3);
    @(negedge clk);
    chk("lat_rd", 32'(psram_rd[0]), 32'd1);
    chk("lat_addr", 32'(psram_addr[0]), 32'd120);
    chk("underrun_clr", 32'(underrun[0]), 32'd0);
    wait_idle(0, 1000);
    @(negedge clk);
    chk("l3_count", 32'(rd_log[0].size()), 32'd40);
    if (rd_log[0].size() == 40) begin
      chk("l3_first", 32'(rd_log[0][0]), 32'd120);
      chk("l3_last", 32'(rd_log[0][39]), 32'd159);
    end
    chk("l3_head", 32'(pix_q[0]), 32'h5A22);
    tick();
    drain(0);

    // line 4 with sparse pops overlapping buffer writes
    start_line(0, 8'd4);
    n = 0;
    while (fetch_active[0] && n < 1000) begin
      pix_rd[0] = pix_valid[0] && ($urandom_range(0, 7) == 0);
      tick();
      n++;
    end
    pix_rd[0] = 1'b0;
    chk("l4_timeout", 32'(fetch_active[0]), 32'd0);
    drain(0);

    // abort line 2 while a read is in flight, restart at line 5
    rd_log[0].delete();
    start_line(0, 8'd2);
    n = 0;
    while (rd_log[0].size() < 3 && n < 200) begin
      tick();
      n++;
    end
    wait_busy(0);
    rd_log[0].delete();
    start_line(0, 8'd5);
    n = 0;
    while (rd_log[0].size() == 0 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_rd_seen", 32'(rd_log[0].size()), 32'd1);
    if (rd_log[0].size() != 0) chk("abort_addr", 32'(rd_log[0][0]), 32'd200);
    wait_idle(0, 1000);
    @(negedge clk);
    chk("abort_head", 32'(pix_q[0]), 32'h5A92);

    // new line in IDLE flushes a full line already buffered
    chk("full_line_valid", 32'(pix_valid[0]), 32'd1);
    tick();
    start_line(0, 8'd1);
    @(negedge clk);
    chk("flush_valid", 32'(pix_valid[0]), 32'd0);
    chk("flush_addr", 32'(psram_addr[0]), 32'd40);
    wait_idle(0, 1000);
    drain(0);

    // reset in the middle of a read
    start_line(0, 8'd7);
    wait_busy(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd", 32'(psram_rd[0]), 32'd0);
    chk("mid_rst_addr", 32'(psram_addr[0]), 32'd0);
    chk("mid_rst_valid", 32'(pix_valid[0]), 32'd0);
    chk("mid_rst_active", 32'(fetch_active[0]), 32'd0);
    chk("mid_rst_underrun", 32'(underrun[0]), 32'd0);
    repeat (8) tick();
    @(negedge clk);
    chk("stale_busy_done", 32'(psram_busy[0]), 32'd0);
    chk("stale_not_written", 32'(pix_valid[0]), 32'd0);

    // address wrap and a completely full buffer
    tick();
    rd_log[1].delete();
    start_line(1, 8'd0);
    @(negedge clk);
    chk("wrap_first", 32'(psram_addr[1]), 32'h1FFFF0);
    wait_idle(1, 2000);
    @(negedge clk);
    chk("wrap_count", 32'(rd_log[1].size()), 32'd64);
    if (rd_log[1].size() == 64) begin
      chk("wrap_top", 32'(rd_log[1][15]), 32'h1FFFFF);
      chk("wrap_zero", 32'(rd_log[1][16]), 32'h000000);
      chk("wrap_last", 32'(rd_log[1][63]), 32'h00002F);
    end
    repeat (20) tick();
    @(negedge clk);
    chk("full_no_rd", 32'(rd_log[1].size()), 32'd64);
    chk("full_head", 32'(pix_q[1]), 32'hA5AA);
    tick();
    pix_rd[1] = 1'b1;
    tick();
    pix_rd[1] = 1'b0;
    @(negedge clk);
    chk("pop_head", 32'(pix_q[1]), 32'hA5AB);
    tick();
    drain(1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
